// File: rtl/cov_monitor.sv
// cov_monitor: per-channel event/coverage counters with a cycle budget and a latched verdict.
// Optional build macro COV_MONITOR_STRICT_EN: over-coverage (covered > events) ends the run at once with code 3.
module cov_monitor #(
    parameter int unsigned NCHAN = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned CYC_W = 32,
    localparam int unsigned SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CYC_W-1:0] cfg_limit,
    input  logic [NCHAN-1:0] ev_valid,
    input  logic [NCHAN-1:0] chk_valid,
    input  logic [NCHAN-1:0] chk_pass,
    input  logic             endsim,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_events,
    output logic [CNT_W-1:0] rd_covered,
    output logic             done,
    output logic             pass,
    output logic [2:0]       code
);

    localparam logic [2:0] CODE_PASS      = 3'd1;
    localparam logic [2:0] CODE_NO_EVENTS = 3'd2;
    localparam logic [2:0] CODE_UNCOVERED = 3'd3;
    localparam logic [2:0] CODE_NO_ENDSIM = 3'd4;
    localparam logic [2:0] CODE_FAIL_CHK  = 3'd5;
    localparam logic [2:0] CODE_LATE_EV   = 3'd6;
    localparam logic [2:0] CODE_SATURATED = 3'd7;

    typedef enum logic [1:0] {ST_RUN, ST_EVAL, ST_DONE} state_t;

    state_t                      state_q, state_d;
    logic [CYC_W-1:0]            cyc_q, cyc_d;
    logic [NCHAN-1:0][CNT_W-1:0] ev_q, ev_d;
    logic [NCHAN-1:0][CNT_W-1:0] cov_q, cov_d;
    logic                        fin_q, fin_d;
    logic                        sat_q, sat_d;
    logic                        done_q, done_d;
    logic                        pass_q, pass_d;
    logic [2:0]                  code_q, code_d;

    logic [CYC_W-1:0] last_cyc;
    logic             fault_chk;
    logic             fault_late;
    logic             all_zero;
    logic             mism;
    logic [2:0]       eval_code;

    // A zero budget behaves like a budget of one cycle.
    assign last_cyc   = (cfg_limit == '0) ? '0 : cfg_limit - CYC_W'(1);
    assign fault_chk  = |(chk_valid & ~chk_pass);
    assign fault_late = fin_q & (|ev_valid);

    always_comb begin
        all_zero = 1'b1;
        mism     = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (ev_q[i] != '0) all_zero = 1'b0;
            if (cov_q[i] != ev_q[i]) mism = 1'b1;
        end
        if (all_zero)    eval_code = CODE_NO_EVENTS;
        else if (mism)   eval_code = CODE_UNCOVERED;
        else if (sat_q)  eval_code = CODE_SATURATED;
        else if (!fin_q) eval_code = CODE_NO_ENDSIM;
        else             eval_code = CODE_PASS;
    end

`ifdef COV_MONITOR_STRICT_EN
    logic over;

    // Would a passing check this cycle push covered past events (including same-cycle events)?
    always_comb begin
        over = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (chk_valid[i] && chk_pass[i] &&
                ((CNT_W+1)'(cov_q[i]) + (CNT_W+1)'(1) >
                 (CNT_W+1)'(ev_q[i]) + (CNT_W+1)'(ev_valid[i])))
                over = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ev_d    = ev_q;
        cov_d   = cov_q;
        fin_d   = fin_q;
        sat_d   = sat_q;
        done_d  = done_q;
        pass_d  = pass_q;
        code_d  = code_q;
        case (state_q)
            ST_RUN: begin
                for (int i = 0; i < NCHAN; i++) begin
                    if (ev_valid[i]) begin
                        if (ev_q[i] == '1) sat_d = 1'b1;
                        else               ev_d[i] = ev_q[i] + CNT_W'(1);
                    end
                    if (chk_valid[i] && chk_pass[i]) begin
                        if (cov_q[i] == '1) sat_d = 1'b1;
                        else                cov_d[i] = cov_q[i] + CNT_W'(1);
                    end
                end
                if (endsim) fin_d = 1'b1;
                if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
                if (fault_chk) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    code_d  = CODE_FAIL_CHK;
                end else if (fault_late) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    code_d  = CODE_LATE_EV;
`ifdef COV_MONITOR_STRICT_EN
                end else if (over) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    code_d  = CODE_UNCOVERED;
`endif
                end else if (cyc_q == last_cyc) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                code_d  = eval_code;
                pass_d  = (eval_code == CODE_PASS);
            end
            ST_DONE: ;
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cyc_q   <= '0;
            ev_q    <= '0;
            cov_q   <= '0;
            fin_q   <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ev_q    <= ev_d;
            cov_q   <= cov_d;
            fin_q   <= fin_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            code_q  <= code_d;
        end
    end

    // Readback mux; selects at or beyond NCHAN read zero.
    always_comb begin
        rd_events  = '0;
        rd_covered = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_events  = ev_q[i];
                rd_covered = cov_q[i];
            end
        end
    end

    assign done = done_q;
    assign pass = pass_q;
    assign code = code_q;

endmodule

// File: doc/cov_monitor.md
# cov_monitor

Synthesizable, parametrised event-coverage monitor for the cache_ctrl verification benches, replacing the single-channel behavioural bench monitor. It counts registered events and covered checks on NCHAN independent channels, enforces a cycle budget, detects failed checks, late events and a missing end-of-sim marker, and reports a latched verdict. It sits beside the DUT in every bench, and in emulation builds, where a behavioural monitor cannot be used.

## Interface
- NCHAN, 4, number of independent coverage channels (1..32)
- CNT_W, 16, width of each per-channel event/covered counter
- CYC_W, 32, width of the cycle-budget counter
- clk  in  1  bench clock
- rst_n  in  1  asynchronous active-low reset
- cfg_limit  in  CYC_W  cycle budget; sampled every cycle while RUN; 0 treated as 1
- ev_valid  in  NCHAN  per-channel "register event" strobe
- chk_valid  in  NCHAN  per-channel "check performed" strobe
- chk_pass  in  NCHAN  check outcome, qualified by chk_valid
- endsim  in  1  end-of-simulation marker pulse
- rd_sel  in  $clog2(NCHAN) (min 1)  channel select for readback
- rd_events  out  CNT_W  event count of selected channel
- rd_covered  out  CNT_W  covered count of selected channel
- done  out  1  verdict valid (sticky)
- pass  out  1  verdict is pass (sticky)
- code  out  3  verdict code (below)

## Operation
- States: RUN, EVAL, DONE. Reset → RUN, all counters 0, finished flag 0, done=0, pass=0, code=0.
- RUN: cycle counter increments each cycle. Per channel, ev_valid increments events[i]; chk_valid&chk_pass increments covered[i]; both strobes on one channel in one cycle both count.
- chk_valid & !chk_pass on any channel → DONE, code=5 (FAIL_CHECK).
- ev_valid on any channel while finished flag set → DONE, code=6 (FAIL_LATE_EVENT).
- endsim sets finished flag (sticky); events in the same cycle as endsim are legal.
- Counters saturate at all-ones and set a sticky sat flag; they never wrap.
- cycle counter == max(cfg_limit,1)-1 with no fault → EVAL.
- EVAL (one cycle), priority order: all events[i]==0 → code=2 (WARN_NO_EVENTS); any covered[i]!=events[i] → code=3 (WARN_UNCOVERED); sat flag set → code=7 (WARN_SATURATED); finished flag 0 → code=4 (FAIL_NO_ENDSIM); else code=1 (PASS). Next state DONE.
- DONE: terminal until reset; counters frozen, all strobes ignored, outputs held.
- pass=1 only for code 1. Code 0 = running.
- Readback: rd_events/rd_covered combinational from rd_sel, valid in all states; rd_sel ≥ NCHAN reads 0.

## Timing
- Fault strobe at edge N → done=1, code set after edge N+1 (one-cycle latency).
- Budget: with cfg_limit=L≥1, EVAL occupies cycle L, done=1 visible after edge L+1 counted from first edge after rst_n release.
- Fault in the same cycle as budget expiry: fault wins, EVAL skipped.
- Multiple faults in one cycle: FAIL_CHECK beats FAIL_LATE_EVENT.
- Counter update visible on readback the cycle after the strobe.
- rst_n assertion in any state clears everything immediately, independent of clk; release re-enters RUN.

## Configuration
- COV_MONITOR_STRICT_EN defined: warning codes 2, 3, 7 are failures (pass=0); additionally any chk_valid on a channel whose covered count would exceed its events count → DONE, code=3 immediately.
- Undefined: codes 2, 3, 7 report done=1, pass=0, and over-coverage is only detected at EVAL.

## Test plan
- NCHAN=4, L=100; ch0 3 ev + 3 passing chk, endsim at cycle 50 → done after edge 101, code=1, pass=1, rd_sel=0 reads 3/3.
- L=20, no strobes at all → code=2 at EVAL; ch1 2 ev, 1 chk, endsim → code=3.
- Balanced ev/chk on ch2, no endsim, L=30 → code=4, pass=0.
- ev on ch3 two cycles after endsim → code=6 one cycle later; further strobes leave counts unchanged.
- chk_valid=1, chk_pass=0 on ch0 at cycle L-1 → code=5, not EVAL verdict; rst_n pulse mid-DONE → code=0, counts 0.
- CNT_W=2, 5 ev + 5 chk on ch0, endsim → counts read 3/3, code=7; with STRICT, 1 ev + 2 chk → code=3 at second chk.
